// File: rtl/sqrt_range_reconst_pipe_if.sv
// Handshake/data bundle for the sqrt range-reconstruction stage.
// master: exponent/mantissa producer side; slave: reconstruction stage.
interface sqrt_range_reconst_pipe_if #(
  parameter int Y_W   = 22,
  parameter int EXP_W = 6,
  parameter int OUT_W = 17
);
  logic             iExpValid;
  logic [EXP_W-1:0] iExp_f;
  logic             iYValid;
  logic [Y_W-1:0]   iY_f;
  logic             oValid;
  logic [OUT_W-1:0] oF;
  logic             oSat;
  logic             oAlignErr;

  modport master (
    output iExpValid, iExp_f, iYValid, iY_f,
    input  oValid, oF, oSat, oAlignErr
  );

  modport slave (
    input  iExpValid, iExp_f, iYValid, iY_f,
    output oValid, oF, oSat, oAlignErr
  );
endinterface

// File: rtl/sqrt_range_reconst_pipe.sv
// Range reconstruction for the sqrt datapath: exp/2 shift, round, saturate.
// Ports: iClk, iRst (sync, active high), bus (slave: exp/mantissa in, result out).
module sqrt_range_reconst_pipe #(
  parameter int Y_W       = 22,
  parameter int EXP_W     = 6,
  parameter int EXP_BIAS  = 6,
  parameter int EXP_DLY   = 3,
  parameter int FRAC_DROP = 7,
  parameter int ROUND     = 1
) (
  input logic iClk,
  input logic iRst,
  sqrt_range_reconst_pipe_if.slave bus
);
  localparam int WW    = Y_W + 2;
  localparam int OUT_W = WW - FRAC_DROP;
  localparam int KW    = OUT_W + 1;
  localparam int LKW   = 2 * WW - FRAC_DROP + 1;

  logic [EXP_DLY-1:0] dlyVld;
  logic [EXP_W-1:0]   dlyExp [EXP_DLY];
  logic               dVld;
  logic [EXP_W-1:0]   dExp;
  logic               accept;

  assign dVld   = dlyVld[EXP_DLY-1];
  assign dExp   = dlyExp[EXP_DLY-1];
  assign accept = bus.iYValid & dVld;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      dlyVld <= '0;
      for (int i = 0; i < EXP_DLY; i++)
        dlyExp[i] <= '0;
    end else begin
      dlyVld[0] <= bus.iExpValid;
      dlyExp[0] <= bus.iExp_f;
      for (int i = 1; i < EXP_DLY; i++) begin
        dlyVld[i] <= dlyVld[i-1];
        dlyExp[i] <= dlyExp[i-1];
      end
    end
  end

  logic [EXP_W:0]    biasV, expV, sMag, sInc;
  logic [EXP_W:0]    lAmt, rAmt;
  logic              shl;
  logic [WW-1:0]     word, rWord;
  logic [2*WW-1:0]   lWide;
  logic [LKW-1:0]    lKeep;
  logic [KW-1:0]     rKeep, shKeep;
  logic              shOvf;

  // Kept bits are word[WW-1:FRAC_DROP-1]: output field plus round bit.
  always_comb begin
    biasV = (EXP_W+1)'(EXP_BIAS);
    expV  = {1'b0, dExp};
    shl   = biasV >= expV;
    sMag  = shl ? biasV - expV : expV - biasV;
    sInc  = sMag + (EXP_W+1)'(1);
    lAmt  = sInc >> 1;
    rAmt  = sMag >> 1;
    word  = {2'b00, bus.iY_f};
    lWide = {{WW{1'b0}}, word} << lAmt;
    lKeep = LKW'(lWide >> (FRAC_DROP - 1));
    rWord = word >> rAmt;
    rKeep = KW'(rWord >> (FRAC_DROP - 1));
    if (shl) begin
      shKeep = lKeep[KW-1:0];
      if (int'(lAmt) >= WW)
        shOvf = bus.iY_f != '0;
      else
        shOvf = |lKeep[LKW-1:KW];
    end else begin
      shKeep = rKeep;
      shOvf  = 1'b0;
    end
  end

  logic          s1Vld;
  logic [KW-1:0] s1Keep;
  logic          s1Ovf;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1Vld  <= 1'b0;
      s1Keep <= '0;
      s1Ovf  <= 1'b0;
    end else begin
      s1Vld <= accept;
      if (accept) begin
        s1Keep <= shKeep;
        s1Ovf  <= shOvf;
      end
    end
  end

  logic [OUT_W-1:0] q;
  logic             rnd;
  logic [OUT_W:0]   sum;
  logic             sat;

  always_comb begin
    q   = s1Keep[KW-1:1];
    rnd = (ROUND != 0) ? s1Keep[0] : 1'b0;
    sum = {1'b0, q} + {{OUT_W{1'b0}}, rnd};
    sat = s1Ovf | sum[OUT_W];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      bus.oValid    <= 1'b0;
      bus.oF        <= '0;
      bus.oSat      <= 1'b0;
      bus.oAlignErr <= 1'b0;
    end else begin
      bus.oValid <= s1Vld;
      if (s1Vld) begin
        bus.oF   <= sat ? '1 : sum[OUT_W-1:0];
        bus.oSat <= sat;
      end
      if (bus.iYValid != dVld)
        bus.oAlignErr <= 1'b1;
    end
  end
endmodule
